// File: rtl/alu_arbiter_2ch.sv
// Two-requester 8-bit ALU front end: round-robin arbitration, operand capture,
// and a fixed IDLE -> EXEC -> DONE sequence with registered result outputs.
module alu_arbiter_2ch (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] sel0,
  input  logic [2:0] sel1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done,
  output logic       owner,
  output logic [7:0] y,
  output logic       cy,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] a;
    logic [7:0] b;
  } op_t;

  state_t         state;
  logic           ptr;
  op_t            op_q;
  op_t [1:0]      req_op;
  logic           win;
  logic [8:0]     res;

  assign req_op[0] = '{sel: sel0, a: a0, b: b0};
  assign req_op[1] = '{sel: sel1, a: a1, b: b1};

  // A lone requester wins outright; a tie goes to the priority pointer.
  assign win  = (req0 & req1) ? ptr : req1;
  assign busy = (state != IDLE);

  // res[8] carries the add carry-out or the subtract borrow.
  always_comb begin
    res = 9'h000;
    case (op_q.sel)
      3'b000: res = 9'h000;
      3'b001: res = {1'b0, op_q.a & op_q.b};
      3'b010: res = {1'b0, op_q.a | op_q.b};
      3'b011: res = {1'b0, op_q.a} + {1'b0, op_q.b};
      3'b100: res = {(op_q.a < op_q.b), 8'(op_q.a - op_q.b)};
      3'b101: res = {1'b0, op_q.a ^ op_q.b};
      3'b110: res = {1'b0, ~op_q.a};
      3'b111: res = 9'h0FF;
      default: res = 9'h000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 1'b0;
      owner <= 1'b0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done  <= 1'b0;
      y     <= 8'h00;
      cy    <= 1'b0;
      op_q  <= '0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            op_q  <= req_op[win];
            owner <= win;
            gnt0  <= ~win;
            gnt1  <= win;
            state <= EXEC;
          end
        end
        EXEC: begin
          y     <= res[7:0];
          cy    <= res[8];
          done  <= 1'b1;
          ptr   <= ~owner;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter_2ch.sv
// Directed bench for alu_arbiter_2ch: hand-computed vectors checked with
// immediate assertions, sampled 1ns after each rising edge.
module tb_alu_arbiter_2ch;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [2:0] sel0, sel1;
  logic [7:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, done, owner, cy, busy;
  logic [7:0] y;

  int n_cmp = 0;
  int n_err = 0;

  alu_arbiter_2ch dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .sel0(sel0), .sel1(sel1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done(done), .owner(owner),
    .y(y), .cy(cy), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation from requester ch and check grant, result and return to idle.
  task automatic do_op(input string tag, input logic ch, input logic [2:0] sel,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ey, input logic ecy);
    if (ch) begin req1 = 1'b1; sel1 = sel; a1 = a; b1 = b; end
    else    begin req0 = 1'b1; sel0 = sel; a0 = a; b0 = b; end
    step();
    chk({tag, ".gnt"}, {gnt1, gnt0}, ch ? 16'd2 : 16'd1);
    chk({tag, ".busy"}, busy, 1);
    req0 = 1'b0; req1 = 1'b0;
    step();
    chk({tag, ".done"}, {done, owner}, {14'd0, 1'b1, ch});
    chk({tag, ".y"}, {cy, y}, {7'd0, ecy, ey});
    step();
    chk({tag, ".idle"}, {busy, done, gnt1, gnt0}, 0);
    chk({tag, ".hold"}, {cy, y}, {7'd0, ecy, ey});
  endtask

  initial begin
    reset = 1'b1; req0 = 0; req1 = 0;
    sel0 = 0; sel1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    step(); step();
    chk("reset.ctl", {busy, done, gnt1, gnt0, owner}, 0);
    chk("reset.y", {cy, y}, 0);
    reset = 1'b0;

    // Both requesting continuously: grants alternate 0,1,0,1 every 3 cycles.
    req0 = 1'b1; req1 = 1'b1;
    sel0 = 3'b011; a0 = 8'h01; b0 = 8'h02;
    sel1 = 3'b010; a1 = 8'h10; b1 = 8'h01;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("rr.gnt%0d", i), {gnt1, gnt0},
          {14'd0, (i % 6 == 3), (i % 6 == 0)});
      if (i % 3 == 1)
        chk($sformatf("rr.res%0d", i), {owner, y},
            (i % 6 == 1) ? {7'd0, 1'b0, 8'h03} : {7'd0, 1'b1, 8'h11});
    end
    req0 = 1'b0; req1 = 1'b0;
    step(); step();

    do_op("add0", 1'b0, 3'b011, 8'h4F, 8'h1F, 8'h6E, 1'b0);
    do_op("sub1", 1'b1, 3'b100, 8'h1F, 8'h4F, 8'hD0, 1'b1);
    do_op("sub1b", 1'b1, 3'b100, 8'h4F, 8'h1F, 8'h30, 1'b0);

    do_op("op000", 1'b0, 3'b000, 8'h4F, 8'h1F, 8'h00, 1'b0);
    do_op("op001", 1'b0, 3'b001, 8'h4F, 8'h1F, 8'h0F, 1'b0);
    do_op("op010", 1'b0, 3'b010, 8'h4F, 8'h1F, 8'h5F, 1'b0);
    do_op("op011", 1'b0, 3'b011, 8'h4F, 8'h1F, 8'h6E, 1'b0);
    do_op("op100", 1'b0, 3'b100, 8'h4F, 8'h1F, 8'h30, 1'b0);
    do_op("op101", 1'b0, 3'b101, 8'h4F, 8'h1F, 8'h50, 1'b0);
    do_op("op110", 1'b0, 3'b110, 8'h4F, 8'h1F, 8'hB0, 1'b0);
    do_op("op111", 1'b0, 3'b111, 8'h4F, 8'h1F, 8'hFF, 1'b0);
    do_op("addcy", 1'b0, 3'b011, 8'hFF, 8'h01, 8'h00, 1'b1);
    do_op("sub_cy_clr", 1'b0, 3'b100, 8'h05, 8'h03, 8'h02, 1'b0);

    // Last servicing was requester 0, so a tie now goes to requester 1.
    req0 = 1'b1; req1 = 1'b1;
    sel0 = 3'b111; sel1 = 3'b101; a1 = 8'hF0; b1 = 8'h0F;
    step();
    chk("tie.gnt", {gnt1, gnt0}, 2);
    req0 = 1'b0; req1 = 1'b0;
    step();
    chk("tie.res", {owner, cy, y}, {7'd0, 1'b1, 1'b0, 8'hFF});
    step();

    // Operand change after capture must not disturb the result.
    req0 = 1'b1; sel0 = 3'b011; a0 = 8'h4F; b0 = 8'h1F;
    step();
    chk("late.gnt", {gnt1, gnt0}, 1);
    req0 = 1'b0; a0 = 8'h00; sel0 = 3'b000;
    step();
    chk("late.y", {done, cy, y}, {7'd0, 1'b1, 1'b0, 8'h6E});
    step();

    // Reset mid-EXEC aborts without a done pulse and clears the result.
    req0 = 1'b1; sel0 = 3'b111;
    step();
    chk("abort.gnt", gnt0, 1);
    req0 = 1'b0; reset = 1'b1;
    step();
    chk("abort.ctl", {busy, done, gnt1, gnt0}, 0);
    chk("abort.y", {cy, y}, 0);
    reset = 1'b0;
    step();
    chk("abort.nodone", {busy, done}, 0);
    do_op("post_rst", 1'b0, 3'b011, 8'h4F, 8'h1F, 8'h6E, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter_2ch.md
ALU_ARBITER_2CH -- requirements
Module: alu_arbiter_2ch

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 req0, req1  input  1 each  operation request from requester 0 / 1.
REQ-005 sel0, sel1  input  3 each  ALU opcode from requester 0 / 1.
REQ-006 a0, b0, a1, b1  input  8 each  operands from requester 0 / 1.
REQ-007 gnt0, gnt1  output  1 each  registered grant: operands captured for that requester.
REQ-008 done  output  1  registered result-valid pulse.
REQ-009 owner  output  1  requester index of the current/last result, valid when done=1.
REQ-010 y  output  8  registered result; holds value between done pulses.
REQ-011 cy  output  1  registered carry (add) / borrow (sub) flag, updated with y.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, EXEC, DONE.
REQ-014 IDLE: on an edge with req0|req1 high, the block SHALL latch the winner's sel/a/b into internal operand registers, record owner, and enter EXEC; with no request it stays in IDLE.
REQ-015 Arbitration SHALL be round-robin via a 1-bit priority pointer: single request wins outright; both requesting -> pointer side wins.
REQ-016 The pointer SHALL flip to the non-serviced requester on the EXEC->DONE transition; it is unchanged while idle.
REQ-017 EXEC: gnt of the owner SHALL be high for exactly this one cycle, the other gnt low; on the ending edge y/cy load the operation result and the FSM enters DONE.
REQ-018 DONE: done SHALL be high for exactly this one cycle with owner valid; next state is IDLE unconditionally.
REQ-019 Latency: request sampled at edge N -> gnt high cycle N+1 -> done and valid y cycle N+2; minimum spacing between grants is 3 cycles.
REQ-020 Requests SHALL be sampled only in IDLE; req held through EXEC/DONE is ignored there and re-arbitrated in the following IDLE cycle (requester drops req after seeing gnt to avoid a repeat).
REQ-021 Operand changes on a/b/sel after capture SHALL NOT affect the in-flight result.
REQ-022 Opcode map: 000 y=0x00; 001 a&b; 010 a|b; 011 a+b; 100 a-b; 101 a^b; 110 ~a; 111 y=0xFF.
REQ-023 Add/sub SHALL be 8-bit modulo 256; cy = carry-out of 9-bit a+b for 011, cy = 1 when a<b (unsigned borrow) for 100, cy = 0 for all other opcodes.
REQ-024 y and cy SHALL change only on the EXEC->DONE edge (no tri-state, never X/Z after reset).
REQ-025 busy SHALL be decoded from state (high in EXEC and DONE).

Reset
REQ-026 reset high at an edge SHALL force state IDLE, pointer 0, owner 0, gnt0=gnt1=0, done=0, y=0x00, cy=0, operand registers 0.
REQ-027 reset SHALL take priority over every other event, including mid-EXEC or mid-DONE; the aborted operation produces no done pulse.
REQ-028 First request after reset with both req high SHALL grant requester 0.

Verification
REQ-029 req0 only, sel0=011, a0=0x4F, b0=0x1F -> gnt0 one cycle later, done two cycles later, y=0x6E, cy=0, owner=0.
REQ-030 req1 only, sel1=100, a1=0x1F, b1=0x4F -> y=0xD0, cy=1, owner=1; sel1=100 with 0x4F-0x1F -> y=0x30, cy=0.
REQ-031 req0=req1=1 held continuously after reset -> grants alternate 0,1,0,1 with gnt pulses spaced 3 cycles; no cycle with both gnt high.
REQ-032 All 8 opcodes via req0 with a0=0x4F, b0=0x1F -> y = 0x00, 0x0F, 0x5F, 0x6E, 0x30, 0x50, 0xB0, 0xFF; add 0xFF+0x01 -> y=0x00, cy=1.
REQ-033 reset asserted during EXEC -> next cycle busy=0, done=0, y=0x00, cy=0; subsequent req0 completes normally.
REQ-034 a0 changed to 0x00 in the gnt0 cycle of an add 0x4F+0x1F -> y still 0x6E.
